// File: rtl/fa_pkg.sv
// Shared definitions for the bit-serial full-adder datapath:
// FSM state encoding and the truth tables that program the 8:1-mux cell.
package fa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Index is {a, b, cin}; bit n of each table is the cell output for select n.
    localparam logic [7:0] SUM_TT   = 8'b1001_0110;  // odd parity
    localparam logic [7:0] CARRY_TT = 8'b1110_1000;  // majority

endpackage

// File: rtl/fa_mux8.sv
// Full adder built as a pair of 8:1 multiplexers whose data inputs are the
// sum/carry truth tables and whose select lines are {a, b, cin}.
import fa_pkg::*;

module fa_mux8 (
    input  logic [2:0] i_sel,
    output logic       o_sum,
    output logic       o_carry
);

    // Pick the truth-table entry addressed by the operand bits.
    always_comb begin
        o_sum   = SUM_TT[i_sel];
        o_carry = CARRY_TT[i_sel];
    end

endmodule

// File: rtl/serial_fa_adder.sv
// Bit-serial W-bit adder: one bit pair per clock, LSB first, carry held in a
// flop between cycles. start/busy handshake in, one-cycle done strobe out.
import fa_pkg::*;

module serial_fa_adder #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic          w_accept;
    logic          w_last;

    logic [W-1:0]  r_a_sr;
    logic [W-1:0]  r_b_sr;
    logic [W-1:0]  r_sum_sr;
    logic          r_carry;
    logic [CW-1:0] r_cnt;

    logic          w_fa_sum;
    logic          w_fa_carry;
    logic [W-1:0]  w_sum_sr_next;

    fa_mux8 u_fa (
        .i_sel   ({r_a_sr[0], r_b_sr[0], r_carry}),
        .o_sum   (w_fa_sum),
        .o_carry (w_fa_carry)
    );

    // State register; reset discards any add in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus the accept/last-bit decodes used by the datapath.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == LAST_CNT) begin
                    w_last       = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // A start here chains straight into the next add.
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // New sum bit enters at the MSB so after W shifts bit 0 is the LSB result.
    always_comb begin
        w_sum_sr_next = (r_sum_sr >> 1) | (W'(w_fa_sum) << (W - 1));
    end

    // Operand/sum shift registers, carry flop and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_sum_sr <= '0;
            r_carry  <= cin;
            r_cnt    <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_sum_sr <= w_sum_sr_next;
            r_carry  <= w_fa_carry;
            r_cnt    <= r_cnt + CW'(1);
        end else begin
            r_a_sr   <= r_a_sr;
            r_b_sr   <= r_b_sr;
            r_sum_sr <= r_sum_sr;
            r_carry  <= r_carry;
            r_cnt    <= r_cnt;
        end
    end

    // Registered handshake outputs and result; the result is captured from
    // the final shift so it is valid in the done cycle and held afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            busy <= (w_state_next == ST_SHIFT);
            done <= (w_state_next == ST_DONE);
            if (w_last) begin
                sum  <= w_sum_sr_next;
                cout <= w_fa_carry;
            end else begin
                sum  <= sum;
                cout <= cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_fa_adder.sv
// Self-checking bench for serial_fa_adder (W=4) and its fa_mux8 cell.
// Expected results come from plain integer addition a+b+cin.
module tb_serial_fa_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic [2:0]   m_sel;
    logic         m_sum;
    logic         m_carry;

    int n_vec;
    int n_err;

    serial_fa_adder #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    fa_mux8 u_mux (
        .i_sel   (m_sel),
        .o_sum   (m_sum),
        .o_carry (m_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one add from IDLE and check busy window, done strobe and result.
    task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic tc, input string tag);
        logic [W:0] exp_v;
        exp_v = (W+1)'(ta) + (W+1)'(tb_v) + (W+1)'(tc);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        cin   = tc;
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        for (int i = 0; i < W; i++) begin
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL %s busy_window cyc%0d: busy=%b done=%b expected busy=1 done=0",
                         tag, i, busy, done);
            end
            tick();
        end
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_strobe: done=%b busy=%b expected done=1 busy=0", tag, done, busy);
        end
        n_vec++;
        if ({cout, sum} !== exp_v) begin
            n_err++;
            $display("FAIL %s result a=%b b=%b cin=%b: got cout=%b sum=%b expected cout=%b sum=%b",
                     tag, ta, tb_v, tc, cout, sum, exp_v[W], exp_v[W-1:0]);
        end
        tick();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s back_to_idle: done=%b busy=%b expected 0 0", tag, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 4'b0000 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b sum=%b cout=%b expected all 0",
                     busy, done, sum, cout);
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        run_add(4'b0101, 4'b0011, 1'b0, "dir_5p3");
        run_add(4'b1111, 4'b0001, 1'b0, "dir_wrap");
        run_add(4'b1111, 4'b1111, 1'b1, "dir_max");
        run_add(4'b0000, 4'b0000, 1'b0, "dir_zero");
    endtask

    // start held high: accepts only in IDLE/DONE, operands changed while busy.
    task automatic test_back_to_back();
        start = 1'b1;
        a     = 4'b0010;
        b     = 4'b0011;
        cin   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int i = 0; i < W; i++) begin
                n_vec++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b busy k%0d cyc%0d: busy=%b done=%b expected 1 0", k, i, busy, done);
                end
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
                tick();
            end
            a   = 4'b0010;
            b   = 4'b0011;
            cin = 1'b0;
            if (k == 2) start = 1'b0;
            n_vec++;
            if (done !== 1'b1 || busy !== 1'b0 || sum !== 4'b0101 || cout !== 1'b0) begin
                n_err++;
                $display("FAIL b2b done k%0d: done=%b busy=%b sum=%b cout=%b expected 1 0 0101 0",
                         k, done, busy, sum, cout);
            end
        end
        tick();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b idle: done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    // Reset mid-SHIFT must clear outputs without waiting for a clock edge.
    task automatic test_async_reset();
        run_add(4'b1001, 4'b0101, 1'b0, "pre_rst");
        start = 1'b1;
        a     = 4'b0111;
        b     = 4'b0111;
        cin   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 4'b0000 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: busy=%b done=%b sum=%b cout=%b expected all 0",
                     busy, done, sum, cout);
        end
        tick();
        rst = 1'b0;
        tick();
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: busy=%b done=%b expected 0 0", busy, done);
        end
        run_add(4'b0111, 4'b0111, 1'b1, "after_rst");
    endtask

    task automatic test_mux8();
        int ones;
        for (int s = 0; s < 8; s++) begin
            m_sel = 3'(s);
            #1;
            ones = $countones(m_sel);
            n_vec++;
            if (m_sum !== 1'((ones % 2)) || m_carry !== 1'((ones >= 2) ? 1 : 0)) begin
                n_err++;
                $display("FAIL mux8 sel=%b: sum=%b carry=%b expected sum=%0d carry=%0d",
                         m_sel, m_sum, m_carry, ones % 2, (ones >= 2) ? 1 : 0);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 200; t++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom), "random");
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        m_sel = 3'b000;
        test_reset();
        test_mux8();
        test_directed();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
